// File: rtl/cdb_arbiter.sv
// Two-bus common data bus arbiter: one holding buffer per functional unit,
// round-robin selection of up to two buffered results per cycle onto registered CDBs.
module cdb_arbiter #(
    parameter int NUM_FU   = 4,
    parameter int ROB_SIZE = 16,
    parameter int TAG_W    = $clog2(ROB_SIZE) + 1,
    parameter int DATA_W   = 32
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic [NUM_FU-1:0]        i_fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]  i_fu_tag,
    input  logic [NUM_FU*DATA_W-1:0] i_fu_value,
    output logic [NUM_FU-1:0]        o_fu_ready,
    output logic [TAG_W-1:0]         o_cdb1_tag,
    output logic [DATA_W-1:0]        o_cdb1_value,
    output logic [TAG_W-1:0]         o_cdb2_tag,
    output logic [DATA_W-1:0]        o_cdb2_value,
    output logic                     o_busy
);

    localparam int PTR_W = $clog2(NUM_FU);

    logic [NUM_FU-1:0] r_holdValid;
    logic [TAG_W-1:0]  r_holdTag   [NUM_FU];
    logic [DATA_W-1:0] r_holdValue [NUM_FU];
    logic [PTR_W-1:0]  r_rrPtr;
    logic [TAG_W-1:0]  r_cdb1Tag;
    logic [DATA_W-1:0] r_cdb1Value;
    logic [TAG_W-1:0]  r_cdb2Tag;
    logic [DATA_W-1:0] r_cdb2Value;

    logic              w_gntAValid;
    logic [PTR_W-1:0]  w_gntAIdx;
    logic              w_gntBValid;
    logic [PTR_W-1:0]  w_gntBIdx;
    logic [PTR_W-1:0]  w_scanIdx;
    logic [NUM_FU-1:0] w_grant;
    logic [NUM_FU-1:0] w_ready;
    logic [NUM_FU-1:0] w_accept;

    // Modulo-NUM_FU increment that also works when NUM_FU is not a power of two.
    function automatic logic [PTR_W-1:0] wrapIdx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NUM_FU) s = s - NUM_FU;
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        w_gntAValid = 1'b0;
        w_gntAIdx   = '0;
        w_gntBValid = 1'b0;
        w_gntBIdx   = '0;
        w_scanIdx   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            w_scanIdx = wrapIdx(int'(r_rrPtr), k);
            if (r_holdValid[w_scanIdx]) begin
                if (!w_gntAValid) begin
                    w_gntAValid = 1'b1;
                    w_gntAIdx   = w_scanIdx;
                end else if (!w_gntBValid) begin
                    w_gntBValid = 1'b1;
                    w_gntBIdx   = w_scanIdx;
                end
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_gntAValid) w_grant[w_gntAIdx] = 1'b1;
        if (w_gntBValid) w_grant[w_gntBIdx] = 1'b1;
    end

    // A buffer being drained this cycle may be refilled in the same cycle.
    always_comb begin
        w_ready  = '0;
        w_accept = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_ready[i]  = !i_reset && !i_flush && (!r_holdValid[i] || w_grant[i]);
            w_accept[i] = i_fu_valid[i] && w_ready[i] && (i_fu_tag[i*TAG_W +: TAG_W] != '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_holdValid <= '0;
            r_rrPtr     <= '0;
            r_cdb1Tag   <= '0;
            r_cdb1Value <= '0;
            r_cdb2Tag   <= '0;
            r_cdb2Value <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_accept[i]) begin
                    r_holdValid[i] <= 1'b1;
                    r_holdTag[i]   <= i_fu_tag[i*TAG_W +: TAG_W];
                    r_holdValue[i] <= i_fu_value[i*DATA_W +: DATA_W];
                end else if (w_grant[i]) begin
                    r_holdValid[i] <= 1'b0;
                end
            end
            r_cdb1Tag   <= w_gntAValid ? r_holdTag[w_gntAIdx]   : '0;
            r_cdb1Value <= w_gntAValid ? r_holdValue[w_gntAIdx] : '0;
            r_cdb2Tag   <= w_gntBValid ? r_holdTag[w_gntBIdx]   : '0;
            r_cdb2Value <= w_gntBValid ? r_holdValue[w_gntBIdx] : '0;
            if (w_gntBValid) begin
                r_rrPtr <= wrapIdx(int'(w_gntBIdx), 1);
            end else if (w_gntAValid) begin
                r_rrPtr <= wrapIdx(int'(w_gntAIdx), 1);
            end
        end
    end

    assign o_fu_ready   = w_ready;
    assign o_cdb1_tag   = r_cdb1Tag;
    assign o_cdb1_value = r_cdb1Value;
    assign o_cdb2_tag   = r_cdb2Tag;
    assign o_cdb2_value = r_cdb2Value;
    assign o_busy       = |r_holdValid;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the two common data buses (CDB1, CDB2) among the functional units that complete out of order. Each FU hands its finished result (ROB tag and value) to a one-entry holding buffer, and a round-robin arbiter grants up to two buffered results per cycle onto registered CDB outputs. The scheduler, reservation stations, LSQ and ROB snoop these outputs, so the block sits between FU writeback and every CDB consumer.

## Interface
Parameters:
- NUM_FU, 4, number of requesting functional units (2..8)
- TAG_W, `$clog2(ROB_SIZE)+1`, ROB tag width; tag 0 means "no broadcast"
- DATA_W, 32, result value width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset (fixed)
- flush  in  1  synchronous squash on mispredict or exception; same effect on state as reset
- fu_valid  in  NUM_FU  result offered by FU i
- fu_tag  in  NUM_FU x TAG_W  ROB tag of FU i's result
- fu_value  in  NUM_FU x DATA_W  result value of FU i
- fu_ready  out  NUM_FU  holding buffer i can accept this cycle
- cdb1_tag  out  TAG_W  registered CDB1 tag; 0 means idle
- cdb1_value  out  DATA_W  registered CDB1 value
- cdb2_tag  out  TAG_W  registered CDB2 tag; 0 means idle
- cdb2_value  out  DATA_W  registered CDB2 value
- busy  out  1  at least one holding buffer is valid

## Operation
- State:
  - hold_valid[i], hold_tag[i] and hold_value[i] for each FU
  - rr_ptr, log2(NUM_FU) bits
  - the four registered CDB fields
- Accept:
  - FU i's result is captured when fu_valid[i] && fu_ready[i] && fu_tag[i] != 0.
  - A handshake with tag 0 is consumed and dropped. No buffer is written.
- fu_ready[i] = !reset && !flush && (!hold_valid[i] || grant[i]).
  - Same-cycle drain-and-refill is allowed.
- Arbitration (combinational, each cycle):
  - Scan hold_valid starting at rr_ptr, wrapping modulo NUM_FU.
  - The first valid entry found is grant A and goes to CDB1.
  - The next valid entry is grant B and goes to CDB2.
  - Entries beyond the first two wait.
- At the clock edge:
  - cdb1 loads grant A, or tag/value 0 if there is no grant A.
  - cdb2 loads grant B, or 0 if there is no grant B.
  - Granted holds clear unless they are refilled in the same cycle.
- Round-robin pointer:
  - rr_ptr becomes (index of the last grant + 1) mod NUM_FU whenever there is any grant.
  - With no grant, rr_ptr is unchanged.
  - No requester waits more than ceil(NUM_FU/2) cycles once buffered.
- CDB values are held for exactly one cycle. An idle cycle drives tag 0 and value 0.
- CDB1 and CDB2 never carry the same tag in one cycle.
- reset or flush:
  - Clears all hold_valid, both CDB registers and rr_ptr to 0.
  - Takes priority over accept and grant in the same cycle.
  - In-flight results are discarded.
- busy = OR of hold_valid. Registered state only; it does not include fu_valid.

## Timing
- Reset values:
  - hold_valid 0, rr_ptr 0
  - cdb1_tag, cdb1_value, cdb2_tag, cdb2_value all 0
  - busy 0, fu_ready all 0 while reset is high
- In the first cycle after reset deasserts, fu_ready is all 1.
- Latency: a result accepted at edge E appears on the CDB after edge E+1 when it wins arbitration. Minimum latency is 2 cycles from the fu_valid cycle.
- Throughput: 2 results per cycle sustained. A single FU sustains 1 per cycle through refill.
- Backpressure: a losing hold stays valid and fu_ready[i] stays 0. The FU must keep its outputs stable until fu_ready is seen high.
- Wrap-around: rr_ptr at NUM_FU-1 with grants at indices NUM_FU-1 and 0 results in rr_ptr = 1.
- Flush mid-operation: a flush in cycle t gives CDB tags 0 in cycle t+1, even if grants were pending.

## Test plan
- **Reset.** Hold reset 2 cycles.
  - During reset: all outputs 0, fu_ready = 0.
  - Cycle after release: fu_ready = 4'b1111.
- **Single result.** FU2 offers tag 5 / value 0xDEADBEEF in cycle 0.
  - cycle 2: cdb1 = (5, 0xDEADBEEF), cdb2 tag 0.
  - cycle 3: both CDB tags 0, rr_ptr = 3.
- **Four-way contention.** All four FUs offer tags 1..4 in cycle 0, rr_ptr = 0.
  - cycle 2: cdb1 = 1, cdb2 = 2.
  - cycle 3: cdb1 = 3, cdb2 = 4.
  - fu_ready[2] and fu_ready[3] are low in cycle 1.
- **Fairness/wrap.** FU3 and FU0 both stay continuously valid with rr_ptr = 3.
  - Each cycle grants FU3 to CDB1 and FU0 to CDB2.
  - rr_ptr = 1 after every grant cycle.
  - No starvation over 20 cycles.
- **Backpressure plus refill.** FU1 streams tags 1..8 back-to-back while the other FUs are idle.
  - Tags appear in order on cdb1, one per cycle, in cycles 2..9.
  - fu_ready[1] stays high throughout.
- **Flush and tag-0 drop.** Buffer tags 6 and 7, then assert flush in cycle 1.
  - cycle 2: CDB tags 0, busy = 0.
  - Afterwards, an offer with tag 0 leaves busy = 0 and no broadcast appears.
